// File: rtl/target_ctrl.sv
// target_ctrl: game-logic stage ahead of vga_ctrl.
// Owns the target square's position and size, bounces it around the frame
// once per frame tick, scores fire presses that land on the target, freezes
// it for a cooldown after a hit and respawns it at a pseudo-random spot.
// Coord_X / Coord_Y / targetSize only change on frame ticks or on a hit.
// Optional feature macro: TARGET_AUTOSPEED_EN (each hit speeds the target up).
module target_ctrl #(
  parameter int FRAME_WIDTH     = 1280,
  parameter int FRAME_HEIGHT    = 1024,
  parameter int INIT_X          = 576,
  parameter int INIT_Y          = 448,
  parameter int INIT_SIZE       = 128,
  parameter int MIN_SIZE        = 16,
  parameter int SIZE_STEP       = 8,
  parameter int SPEED           = 2,
  parameter int MAX_SPEED       = 8,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        Vsync,
  input  logic        fire_btn,
  input  logic [11:0] MarkerCoord_X,
  input  logic [11:0] MarkerCoord_Y,
  output logic [11:0] Coord_X,
  output logic [11:0] Coord_Y,
  output logic [7:0]  targetSize,
  output logic        hit,
  output logic [15:0] hit_count
);

  typedef enum logic [1:0] {S_MOVE, S_COOLDOWN, S_SPAWN} state_t;

  localparam logic [12:0] FW13   = 13'(FRAME_WIDTH);
  localparam logic [12:0] FH13   = 13'(FRAME_HEIGHT);
  localparam logic [7:0]  MIN8   = 8'(MIN_SIZE);
  localparam logic [7:0]  STEP8  = 8'(SIZE_STEP);
  localparam logic [3:0]  SPEED4 = 4'(SPEED);
  localparam logic [3:0]  MAX4   = 4'(MAX_SPEED);
  localparam logic [7:0]  CD8    = 8'(COOLDOWN_FRAMES);

  state_t      state_reg, state_next;
  logic [11:0] x_reg, x_next, y_reg, y_next;
  logic [7:0]  size_reg, size_next;
  logic        dir_x_reg, dir_x_next, dir_y_reg, dir_y_next;
  logic        hit_reg, hit_next;
  logic [15:0] hit_count_reg, hit_count_next;
  logic [7:0]  cd_reg, cd_next;
  logic [15:0] lfsr_reg;
  logic        vsync_d_reg, fire_d_reg;
  logic [3:0]  speed;

  logic        frame_tick, fire_pulse, overlap;
  logic [12:0] lim_x, lim_y;
  logic [12:0] step_x, step_y;
  logic [12:0] spawn_x, spawn_y;

  assign frame_tick = Vsync & ~vsync_d_reg;
  assign fire_pulse = fire_btn & ~fire_d_reg;

  // Largest legal top-left coordinate for the current size.
  assign lim_x = FW13 - {5'd0, size_reg};
  assign lim_y = FH13 - {5'd0, size_reg};

  // One-axis bounce step: returns {new_dir, new_pos}; dir 1 means increasing.
  function automatic logic [12:0] step_axis(input logic [11:0] pos, input logic dir,
                                            input logic [3:0] spd, input logic [12:0] lim);
    logic [12:0] nx;
    logic [12:0] res;
    if (dir) begin
      nx = {1'b0, pos} + {9'd0, spd};
      if (nx > lim) res = {1'b0, lim[11:0]};
      else          res = {1'b1, nx[11:0]};
    end else begin
      if (pos < {8'd0, spd}) res = {1'b1, 12'd0};
      else                   res = {1'b0, pos - {8'd0, spd}};
    end
    return res;
  endfunction

  // Box overlap on 13 bits so the right/bottom edge sums never wrap.
  always_comb begin
    logic [12:0] tx, ty, mx, my, sz;
    tx = {1'b0, x_reg};
    ty = {1'b0, y_reg};
    mx = {1'b0, MarkerCoord_X};
    my = {1'b0, MarkerCoord_Y};
    sz = {5'd0, size_reg};
    overlap = (mx < tx + sz) && (tx < mx + sz) && (my < ty + sz) && (ty < my + sz);
  end

  // Candidate moves and respawn position; a single subtraction folds the
  // random value into range because the size never exceeds 255.
  always_comb begin
    step_x  = step_axis(x_reg, dir_x_reg, speed, lim_x);
    step_y  = step_axis(y_reg, dir_y_reg, speed, lim_y);
    spawn_x = {2'd0, lfsr_reg[10:0]};
    if (spawn_x > lim_x) spawn_x = spawn_x - lim_x;
    spawn_y = {3'd0, lfsr_reg[9:0]};
    if (spawn_y > lim_y) spawn_y = spawn_y - lim_y;
  end

`ifdef TARGET_AUTOSPEED_EN
  logic [3:0] speed_reg;
  // Each scored hit bumps the speed, capped at the ceiling.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) speed_reg <= SPEED4;
    else if (hit_next && speed_reg < MAX4) speed_reg <= speed_reg + 4'd1;
  end
  assign speed = speed_reg;
`else
  // Fixed speed, still clamped to the ceiling in case of a misconfiguration.
  assign speed = (SPEED4 > MAX4) ? MAX4 : SPEED4;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= S_MOVE;
    else         state_reg <= state_next;
  end

  // Datapath registers, edge detectors and the free-running LFSR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_reg         <= 12'(INIT_X);
      y_reg         <= 12'(INIT_Y);
      size_reg      <= 8'(INIT_SIZE);
      dir_x_reg     <= 1'b1;
      dir_y_reg     <= 1'b1;
      hit_reg       <= 1'b0;
      hit_count_reg <= 16'd0;
      cd_reg        <= 8'd0;
      lfsr_reg      <= 16'hACE1;
      vsync_d_reg   <= 1'b0;
      fire_d_reg    <= 1'b0;
    end else begin
      x_reg         <= x_next;
      y_reg         <= y_next;
      size_reg      <= size_next;
      dir_x_reg     <= dir_x_next;
      dir_y_reg     <= dir_y_next;
      hit_reg       <= hit_next;
      hit_count_reg <= hit_count_next;
      cd_reg        <= cd_next;
      lfsr_reg      <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
      vsync_d_reg   <= Vsync;
      fire_d_reg    <= fire_btn;
    end
  end

  // Next-state and next-datapath logic; a hit takes priority over a move.
  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    size_next      = size_reg;
    dir_x_next     = dir_x_reg;
    dir_y_next     = dir_y_reg;
    hit_next       = 1'b0;
    hit_count_next = hit_count_reg;
    cd_next        = cd_reg;
    case (state_reg)
      S_MOVE: begin
        if (fire_pulse && overlap) begin
          hit_next = 1'b1;
          if (hit_count_reg != 16'hFFFF) hit_count_next = hit_count_reg + 16'd1;
          if (size_reg < MIN8 + STEP8) size_next = MIN8;
          else                         size_next = size_reg - STEP8;
          cd_next    = CD8;
          state_next = S_COOLDOWN;
        end else if (frame_tick) begin
          dir_x_next = step_x[12];
          x_next     = step_x[11:0];
          dir_y_next = step_y[12];
          y_next     = step_y[11:0];
        end
      end
      S_COOLDOWN: begin
        if (frame_tick) begin
          cd_next = cd_reg - 8'd1;
          if (cd_reg <= 8'd1) begin
            cd_next    = 8'd0;
            state_next = S_SPAWN;
          end
        end
      end
      S_SPAWN: begin
        if (frame_tick) begin
          x_next     = spawn_x[11:0];
          y_next     = spawn_y[11:0];
          dir_x_next = lfsr_reg[11];
          dir_y_next = lfsr_reg[12];
          state_next = S_MOVE;
        end
      end
      default: state_next = S_MOVE;
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    Coord_X    = x_reg;
    Coord_Y    = y_reg;
    targetSize = size_reg;
    hit        = hit_reg;
    hit_count  = hit_count_reg;
  end

endmodule

// File: tb/tb_target_ctrl.sv
// Directed testbench for target_ctrl with a queue-based scoreboard.
module tb_target_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        Vsync = 1'b0;
  logic        fire_btn = 1'b0;
  logic [11:0] MarkerCoord_X = '0;
  logic [11:0] MarkerCoord_Y = '0;
  logic [11:0] Coord_X, Coord_Y;
  logic [7:0]  targetSize;
  logic        hit;
  logic [15:0] hit_count;

  int checks = 0;
  int errors = 0;

  target_ctrl dut (
    .clk(clk), .resetn(resetn), .Vsync(Vsync), .fire_btn(fire_btn),
    .MarkerCoord_X(MarkerCoord_X), .MarkerCoord_Y(MarkerCoord_Y),
    .Coord_X(Coord_X), .Coord_Y(Coord_Y), .targetSize(targetSize),
    .hit(hit), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // Running count of cycles with hit asserted.
  int hit_mon = 0;
  always @(posedge clk) if (hit === 1'b1) hit_mon <= hit_mon + 1;

  typedef struct {
    string       tag;
    logic [11:0] x;
    logic [11:0] y;
    logic [7:0]  sz;
    logic        h;
    logic [15:0] hc;
  } exp_t;
  exp_t sb[$];

  logic [15:0] lfsr_at_tick;

  task automatic push_exp(input string tag, input int x, input int y, input int sz,
                          input int h, input int hc);
    exp_t e;
    e.tag = tag; e.x = 12'(x); e.y = 12'(y); e.sz = 8'(sz); e.h = 1'(h); e.hc = 16'(hc);
    sb.push_back(e);
  endtask

  task automatic check_val(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected >0");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val({e.tag, ".x"},    int'(Coord_X),    int'(e.x));
      check_val({e.tag, ".y"},    int'(Coord_Y),    int'(e.y));
      check_val({e.tag, ".size"}, int'(targetSize), int'(e.sz));
      check_val({e.tag, ".hit"},  int'(hit),        int'(e.h));
      check_val({e.tag, ".hcnt"}, int'(hit_count),  int'(e.hc));
      $display("txn %s: X=%0d Y=%0d size=%0d hit=%0d hit_count=%0d",
               e.tag, Coord_X, Coord_Y, targetSize, hit, hit_count);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; Vsync = 1'b0; fire_btn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // One frame tick: Vsync rises for one cycle; outputs settled on return.
  task automatic tick();
    @(negedge clk);
    Vsync = 1'b1;
    lfsr_at_tick = m_lfsr;
    @(negedge clk);
    Vsync = 1'b0;
  endtask

  // One-cycle fire press; on return the cycle after the press is visible.
  task automatic fire();
    @(negedge clk);
    fire_btn = 1'b1;
    @(negedge clk);
    fire_btn = 1'b0;
  endtask

  initial begin
    int base;
    int sx, sy;

    // 1: reset state and first tick
    do_reset();
    push_exp("reset", 576, 448, 128, 0, 0);
    pop_check();
    push_exp("tick1", 578, 450, 128, 0, 0);
    tick();
    pop_check();

    // 2: bounce off right and bottom edges
    do_reset();
    MarkerCoord_X = 12'd0; MarkerCoord_Y = 12'd0;
    for (int k = 1; k <= 300; k++) begin
      case (k)
        224: push_exp("t224", 1024, 896, 128, 0, 0);
        225: push_exp("t225", 1026, 896, 128, 0, 0);
        226: push_exp("t226", 1028, 894, 128, 0, 0);
        288: push_exp("t288", 1152, 770, 128, 0, 0);
        289: push_exp("t289", 1152, 768, 128, 0, 0);
        290: push_exp("t290", 1150, 766, 128, 0, 0);
        300: push_exp("t300", 1130, 746, 128, 0, 0);
        default: ;
      endcase
      tick();
      if (k == 224 || k == 225 || k == 226 || k == 288 || k == 289 || k == 290 || k == 300)
        pop_check();
    end

    // 4: miss is ignored; held button scores once
    do_reset();
    MarkerCoord_X = 12'd0; MarkerCoord_Y = 12'd0;
    push_exp("miss", 576, 448, 128, 0, 0);
    fire();
    pop_check();
    MarkerCoord_X = 12'd600; MarkerCoord_Y = 12'd460;
    base = hit_mon;
    @(negedge clk);
    fire_btn = 1'b1;
    repeat (100) @(negedge clk);
    fire_btn = 1'b0;
    push_exp("held", 576, 448, 120, 0, 1);
    pop_check();
    check_val("held_pulses", hit_mon - base, 1);

    // 3: hit before any tick
    do_reset();
    MarkerCoord_X = 12'd600; MarkerCoord_Y = 12'd460;
    push_exp("hit", 576, 448, 120, 1, 1);
    fire();
    pop_check();
    push_exp("hit_end", 576, 448, 120, 0, 1);
    @(negedge clk);
    pop_check();

    // 5: cooldown freeze, fire ignored, spawn on tick 31
    push_exp("cd_fire", 576, 448, 120, 0, 1);
    fire();
    pop_check();
    for (int k = 1; k <= 30; k++) tick();
    push_exp("cd_t30", 576, 448, 120, 0, 1);
    pop_check();
    tick();
    sx = int'(lfsr_at_tick[10:0]);
    if (sx > 1160) sx = sx - 1160;
    sy = int'(lfsr_at_tick[9:0]);
    if (sy > 904) sy = sy - 904;
    push_exp("spawn", sx, sy, 120, 0, 1);
    pop_check();
    check_val("inv_x", (int'(Coord_X) + int'(targetSize) <= 1280) ? 1 : 0, 1);
    check_val("inv_y", (int'(Coord_Y) + int'(targetSize) <= 1024) ? 1 : 0, 1);

    // 6: asynchronous reset in the middle of a cooldown
    do_reset();
    MarkerCoord_X = 12'd600; MarkerCoord_Y = 12'd460;
    fire();
    repeat (5) tick();
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    push_exp("async_rst", 576, 448, 128, 0, 0);
    pop_check();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    MarkerCoord_X = 12'd0; MarkerCoord_Y = 12'd0;
    for (int k = 1; k <= 31; k++) tick();
    push_exp("post_rst", 638, 510, 128, 0, 0);
    pop_check();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
